float_op_arbiter: RTL

- Shares one AddFloat core (add/sub, IEEE754 single) among NREQ requesters using round-robin arbitration.
- Sequences the core's level-style dataIn/dataOut handshake. Snapshots the winner's operands, returns the result with a one-cycle done pulse, and inserts a recovery gap between operations.
- Sits between the asymmetry/coefficient computations and the shared AddFloat instance, replacing per-computation adder instances.

---
 rtl/float_op_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/float_op_arbiter.sv
// Round-robin arbiter sharing one AddFloat core among NREQ requesters.
// Snapshots the winner's operands, runs the level dataIn/dataOut handshake, and returns the result with a done pulse.

module float_op_arbiter_lane #(
    parameter int IW  = 2,
    parameter int IDX = 0
) (
    input  logic          req,
    input  logic [IW-1:0] start,
    input  logic [31:0]   x_slice,
    input  logic [31:0]   y_slice,
    output logic          hi,
    output logic [31:0]   x,
    output logic [31:0]   y
);
    // hi marks a request at or after the rotating start point
    assign hi = req && (IW'(IDX) >= start);
    assign x  = x_slice;
    assign y  = y_slice;
endmodule

module float_op_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   sub_in,
    input  logic [32*NREQ-1:0] x_in,
    input  logic [32*NREQ-1:0] y_in,
    output logic [NREQ-1:0]   done,
    output logic [31:0]       result,
    output logic              err,
    output logic              busy,
    output logic              core_dataIn,
    output logic              core_sub,
    output logic [31:0]       core_x,
    output logic [31:0]       core_y,
    input  logic              core_dataOut,
    input  logic [31:0]       core_result
);
    localparam int          IW   = $clog2(NREQ);
    localparam int          CW   = $clog2(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

    state_t                 state;
    logic [IW-1:0]          last, gnt, start, win, hi_idx, lo_idx;
    logic [CW-1:0]          cnt;
    logic [NREQ-1:0]        hi;
    logic [NREQ-1:0][31:0]  xa, ya;

    assign start = (last == IW'(NREQ-1)) ? '0 : last + 1'b1;

    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_lane
            float_op_arbiter_lane #(.IW(IW), .IDX(i)) u_lane (
                .req     (req[i]),
                .start   (start),
                .x_slice (x_in[32*i +: 32]),
                .y_slice (y_in[32*i +: 32]),
                .hi      (hi[i]),
                .x       (xa[i]),
                .y       (ya[i])
            );
        end
    endgenerate

    // Lowest index at/after start wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (hi[k])  hi_idx = IW'(k);
            if (req[k]) lo_idx = IW'(k);
        end
        win = (|hi) ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= IW'(NREQ-1);
            gnt         <= '0;
            cnt         <= '0;
            done        <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            core_dataIn <= 1'b0;
            core_sub    <= 1'b0;
            core_x      <= '0;
            core_y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt         <= win;
                        last        <= win;
                        core_x      <= xa[win];
                        core_y      <= ya[win];
                        core_sub    <= sub_in[win];
                        core_dataIn <= 1'b1;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (core_dataOut) begin
                        result      <= core_result;
                        done        <= NREQ'(1) << gnt;
                        core_dataIn <= 1'b0;
                        state       <= GAP;
                    end else if (!req[gnt]) begin
                        core_dataIn <= 1'b0;
                        state       <= GAP;
                    end else if (cnt == CW'(TIMEOUT-1)) begin
                        result      <= QNAN;
                        done        <= NREQ'(1) << gnt;
                        err         <= 1'b1;
                        core_dataIn <= 1'b0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    // One idle cycle with dataIn low so the core's input flag clears
                    done  <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
